// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low per slot, synchronises and
// debounces the columns, and reports each confirmed press as a 4-bit key code.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  output logic [31:0] number,
  output logic [1:0]  pressed
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  localparam logic [1:0] SCAN      = 2'd0;
  localparam logic [1:0] DEB_PRESS = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] DEB_REL   = 2'd3;

  logic [1:0]    state;
  logic [3:0]    cols_meta;
  logic [3:0]    cols_sync;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    code_q;
  logic          held_q;
  logic          strobe_q;

  logic          sample;
  logic          any_low;
  logic          col_low;
  logic [1:0]    low_col;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'd0;
    case ({r, c})
      4'h0: k = 4'd1;
      4'h1: k = 4'd2;
      4'h2: k = 4'd3;
      4'h3: k = 4'd10;
      4'h4: k = 4'd4;
      4'h5: k = 4'd5;
      4'h6: k = 4'd6;
      4'h7: k = 4'd11;
      4'h8: k = 4'd7;
      4'h9: k = 4'd8;
      4'ha: k = 4'd9;
      4'hb: k = 4'd12;
      4'hc: k = 4'd14;
      4'hd: k = 4'd0;
      4'he: k = 4'd15;
      4'hf: k = 4'd13;
    endcase
    return k;
  endfunction

  assign sample  = (slot_cnt == SLOT_LAST);
  assign any_low = ~&cols_sync;
  assign col_low = ~cols_sync[col_idx];

  // Lowest-index low column wins when several keys in the row are down.
  always_comb begin
    low_col = 2'd3;
    if (!cols_sync[0])      low_col = 2'd0;
    else if (!cols_sync[1]) low_col = 2'd1;
    else if (!cols_sync[2]) low_col = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      cols_meta <= 4'hf;
      cols_sync <= 4'hf;
      slot_cnt  <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      deb_cnt   <= '0;
      code_q    <= 4'd0;
      held_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      cols_meta <= cols;
      cols_sync <= cols_meta;
      strobe_q  <= 1'b0;
      slot_cnt  <= sample ? '0 : slot_cnt + 1'b1;
      if (sample) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              col_idx <= low_col;
              deb_cnt <= DEB_ONE;
              if (DEBOUNCE_CNT == 1) begin
                state    <= HELD;
                code_q   <= keymap(row_idx, low_col);
                held_q   <= 1'b1;
                strobe_q <= 1'b1;
              end else begin
                state <= DEB_PRESS;
              end
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end
          DEB_PRESS: begin
            if (col_low) begin
              if (deb_cnt == DEB_LAST) begin
                state    <= HELD;
                code_q   <= keymap(row_idx, col_idx);
                held_q   <= 1'b1;
                strobe_q <= 1'b1;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              // A failed press debounce behaves like an idle scan sample.
              state   <= SCAN;
              row_idx <= row_idx + 2'd1;
            end
          end
          HELD: begin
            if (!col_low) begin
              deb_cnt <= DEB_ONE;
              if (DEBOUNCE_CNT == 1) begin
                state   <= SCAN;
                held_q  <= 1'b0;
                row_idx <= row_idx + 2'd1;
              end else begin
                state <= DEB_REL;
              end
            end
          end
          DEB_REL: begin
            if (!col_low) begin
              if (deb_cnt == DEB_LAST) begin
                state   <= SCAN;
                held_q  <= 1'b0;
                row_idx <= row_idx + 2'd1;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  // pressed[0] is a level while the key is held; pressed[1] is a single-cycle
  // strobe coinciding with the first cycle of the level and the new number.
  assign rows    = ~(4'b0001 << row_idx);
  assign number  = {28'd0, code_q};
  assign pressed = {strobe_q, held_q};

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model driving cols from rows
// and a strobe scoreboard checking each reported key code in order.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [31:0] number;
  logic [1:0]  pressed;

  logic [15:0] keys;
  int          pass_cnt;
  int          total_cnt;
  int          strobe_cnt;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          adv;
    logic [3:0]  rows;
    logic [1:0]  pressed;
    logic [3:0]  number;
    int          strobes;
  } step_t;

  step_t steps[$];

  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K14 = 16'h1000;
  localparam logic [15:0] K2  = 16'h0002;
  localparam logic [15:0] K10 = 16'h0008;
  localparam logic [15:0] K15 = 16'h4000;
  localparam logic [15:0] K9  = 16'h0400;
  localparam logic [15:0] K7  = 16'h0100;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cols   (cols),
    .rows   (rows),
    .number (number),
    .pressed(pressed)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad model: a held key at (r,c) pulls column c low while row r is driven
  always_comb begin
    cols = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: actual %0d required %0d", name, act, exp);
    else pass_cnt++;
  endtask

  // scoreboard: every strobe must carry the next expected code
  always @(negedge clk) begin
    if (pressed[1] === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL strobe_code: actual strobe with number %0d required no strobe", number);
      end else begin
        check("strobe_code", number, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic apply(input step_t s, input string tag);
    keys = s.keys;
    repeat (s.adv) @(negedge clk);
    #1;
    check({tag, " rows"},    32'(rows),    32'(s.rows));
    check({tag, " pressed"}, 32'(pressed), 32'(s.pressed));
    check({tag, " number"},  number,       {28'd0, s.number});
    check({tag, " strobes"}, 32'(strobe_cnt), 32'(s.strobes));
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    strobe_cnt = 0;
    keys       = 16'h0;
    rst        = 1'b1;
    exp_q      = '{4'd5, 4'd14, 4'd2, 4'd15, 4'd9, 4'd7, 4'd7};

    // idle scan rotation
    steps.push_back(step_t'{16'h0, 0, 4'b1110, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{16'h0, 4, 4'b1101, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{16'h0, 4, 4'b1011, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{16'h0, 3, 4'b1011, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{16'h0, 1, 4'b0111, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{16'h0, 4, 4'b1110, 2'b00, 4'd0, 0});
    // key 5 (r1c1): press latency, single strobe, release, hold of number
    steps.push_back(step_t'{K5, 4, 4'b1101, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{K5, 4, 4'b1101, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{K5, 7, 4'b1101, 2'b00, 4'd0, 0});
    steps.push_back(step_t'{K5, 1, 4'b1101, 2'b11, 4'd5, 1});
    steps.push_back(step_t'{K5, 1, 4'b1101, 2'b01, 4'd5, 1});
    steps.push_back(step_t'{K5, 11, 4'b1101, 2'b01, 4'd5, 1});
    steps.push_back(step_t'{16'h0, 11, 4'b1101, 2'b01, 4'd5, 1});
    steps.push_back(step_t'{16'h0, 1, 4'b1011, 2'b00, 4'd5, 1});
    // key 14 (r3c0): bounce aborts debounce, then steady press
    steps.push_back(step_t'{K14, 4, 4'b0111, 2'b00, 4'd5, 1});
    steps.push_back(step_t'{K14, 4, 4'b0111, 2'b00, 4'd5, 1});
    steps.push_back(step_t'{16'h0, 4, 4'b1110, 2'b00, 4'd5, 1});
    steps.push_back(step_t'{K14, 12, 4'b0111, 2'b00, 4'd5, 1});
    steps.push_back(step_t'{K14, 11, 4'b0111, 2'b00, 4'd5, 1});
    steps.push_back(step_t'{K14, 1, 4'b0111, 2'b11, 4'd14, 2});
    steps.push_back(step_t'{K14, 1, 4'b0111, 2'b01, 4'd14, 2});
    steps.push_back(step_t'{K14, 3, 4'b0111, 2'b01, 4'd14, 2});
    steps.push_back(step_t'{16'h0, 11, 4'b0111, 2'b01, 4'd14, 2});
    steps.push_back(step_t'{16'h0, 1, 4'b1110, 2'b00, 4'd14, 2});
    // keys 2 and 10 together, then 15 in another row ignored while held
    steps.push_back(step_t'{K2 | K10, 12, 4'b1110, 2'b11, 4'd2, 3});
    steps.push_back(step_t'{K2 | K10, 1, 4'b1110, 2'b01, 4'd2, 3});
    steps.push_back(step_t'{K2 | K10, 3, 4'b1110, 2'b01, 4'd2, 3});
    steps.push_back(step_t'{K2 | K10 | K15, 16, 4'b1110, 2'b01, 4'd2, 3});
    steps.push_back(step_t'{16'h0, 12, 4'b1101, 2'b00, 4'd2, 3});
    steps.push_back(step_t'{K15, 19, 4'b0111, 2'b00, 4'd2, 3});
    steps.push_back(step_t'{K15, 1, 4'b0111, 2'b11, 4'd15, 4});
    steps.push_back(step_t'{K15, 4, 4'b0111, 2'b01, 4'd15, 4});
    steps.push_back(step_t'{16'h0, 12, 4'b1110, 2'b00, 4'd15, 4});

    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < steps.size(); i++)
      apply(steps[i], $sformatf("step%0d", i));

    // release glitch while key 9 (r2c2) is held
    apply(step_t'{K9, 20, 4'b1011, 2'b11, 4'd9, 5}, "k9 confirm");
    apply(step_t'{K9, 4, 4'b1011, 2'b01, 4'd9, 5}, "k9 held");
    apply(step_t'{16'h0, 4, 4'b1011, 2'b01, 4'd9, 5}, "k9 glitch");
    apply(step_t'{K9, 12, 4'b1011, 2'b01, 4'd9, 5}, "k9 rehold");

    // reset while key 7 (r2c0) is held, then re-detection
    apply(step_t'{K7, 12, 4'b0111, 2'b00, 4'd9, 5}, "k9 release");
    apply(step_t'{K7, 24, 4'b1011, 2'b11, 4'd7, 6}, "k7 confirm");
    apply(step_t'{K7, 4, 4'b1011, 2'b01, 4'd7, 6}, "k7 held");
    rst = 1'b1;
    apply(step_t'{K7, 1, 4'b1110, 2'b00, 4'd0, 6}, "k7 reset");
    rst = 1'b0;
    apply(step_t'{K7, 19, 4'b1011, 2'b00, 4'd0, 6}, "k7 redebounce");
    apply(step_t'{K7, 1, 4'b1011, 2'b11, 4'd7, 7}, "k7 reconfirm");
    apply(step_t'{K7, 1, 4'b1011, 2'b01, 4'd7, 7}, "k7 reheld");

    check("exp_q drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, synchronises and debounces the column inputs, and encodes each confirmed key press into a 4-bit key code.
- Sits directly upstream of the calculator operand reader and drives its number/pressed inputs.
- Reports digits 0-9 plus control codes 10-15. 14 (*) selects operand 2; 15 (#) selects operand 1.

Parameters:
- SCAN_DIV, 50000, clock cycles each row is driven per scan slot; legal range 4 or more.
- DEBOUNCE_CNT, 4, consecutive agreeing samples (one per slot) that confirm a press or a release; legal range 1 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cols  in  4  keypad columns, active-low, externally pulled up, asynchronous.
- rows  out  4  keypad row drive, active-low, one-hot-zero.
- number  out  32  confirmed key code, zero-extended (bits 31:4 always 0).
- pressed  out  2  bit0 = high while a debounced key is held; bit1 = one-cycle strobe on confirmation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Values on reset:
  - rows=4'b1110, number=0, pressed=2'b00.
  - state=SCAN, slot counter=0, row index=0, debounce counter=0.
  - Synchroniser flops are set to 4'b1111.
- Reset mid-press: the block returns to SCAN. A key still held after reset is re-debounced and reported as a new press.
- Column synchroniser: cols passes through two flops before use. Every "sample" below is the synchronised value taken in the last cycle of a SCAN_DIV slot.
- Slot counter: counts 0..SCAN_DIV-1 and wraps. A sample is taken when the counter equals SCAN_DIV-1.
- Keymap, row r / column c:
  - r0: 1, 2, 3, 10.
  - r1: 4, 5, 6, 11.
  - r2: 7, 8, 9, 12.
  - r3: 14, 0, 15, 13.
- State SCAN:
  - At each sample, if any synchronised column is low, lock the current row and latch the lowest-index low column. Load debounce count=1 and go to DEB_PRESS. If DEBOUNCE_CNT=1, go straight to HELD.
  - Otherwise advance the row index 0->1->2->3->0 and drive rows accordingly from the next cycle.
- State DEB_PRESS:
  - The row stays locked.
  - At each sample, if the latched column is still low, increment the count. Reaching DEBOUNCE_CNT goes to HELD.
  - If the latched column is high, go to SCAN. The row then advances normally.
- Entering HELD:
  - number is updated with the keymap code in the cycle after the confirming sample.
  - pressed[0] is set in that same cycle.
  - pressed[1] is high for exactly that one cycle.
- State HELD:
  - The row stays locked; keys in other rows and other columns are ignored.
  - At each sample, if the latched column is high, load count=1 and go to DEB_REL.
- State DEB_REL:
  - At each sample, a high column increments the count. Reaching DEBOUNCE_CNT goes to SCAN, clears pressed[0] in the next cycle, and resumes scanning from the next row.
  - A low column returns to HELD with no new strobe.
- Hold behaviour: number holds its last code after release until the next confirmed press.
- Simultaneous keys in one row: the lowest column index wins. Keys in different rows: the first row scanned wins.
- Press latency (row already selected): pressed rises (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the first qualifying sample.
- Worst-case detection: 4*SCAN_DIV+2 cycles after the column goes low.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, keypad model driving cols from rows):
- Reset, no keys -> rows cycle 1110,1101,1011,0111 every 4 cycles; pressed=00, number=0.
- Hold key r1c1 (code 5) steady -> pressed[1] pulses once, pressed[0] rises 9 cycles after the first low sample, number=5; on release pressed[0] falls after 3 high samples, number stays 5.
- Bounce r3c0 (code 14) low-high-low on consecutive samples, then steady -> no strobe during the bounce; a single strobe with number=14 after 3 consecutive low samples.
- Press r0c1 and r0c3 together -> number=2. While 2 is held, also press r3c2 (code 15) -> no new strobe; release both, then press r3c2 alone -> number=15.
- Release glitch during HELD of code 9: one high sample then low -> pressed[0] stays 1 and no extra strobe.
- Assert rst during HELD of code 7 -> next cycle pressed=00, number=0, rows=1110; key still held -> re-detected with a fresh strobe and number=7.
